// File: rtl/switch_conditioner.sv
// switch_conditioner: two-flop synchronizer plus per-bit debounce with edge pulses.
// Optional macro SWITCH_CONDITIONER_FALL_PULSE_EN builds the sw_fall pulse registers.
`default_nettype none

module switch_conditioner #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int                 C_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_TERM  = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_clean;
    logic [WIDTH-1:0]   r_rise;
    logic [C_CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_term;
    logic [WIDTH-1:0]   w_load;

    // A bit loads only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        w_diff = r_sync2 ^ r_clean;
        w_term = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_term[i] = (r_cnt[i] == C_TERM);
        end
        w_load = w_diff & w_term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_clean <= '0;
            r_rise  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
            r_clean <= r_clean ^ w_load;
            r_rise  <= w_load & r_sync2;
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_term[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + C_ONE;
                end
            end
        end
    end

`ifdef SWITCH_CONDITIONER_FALL_PULSE_EN
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fall <= '0;
        end else begin
            r_fall <= w_load & ~r_sync2;
        end
    end

    assign sw_fall = r_fall;
`else
    assign sw_fall = '0;
`endif

    assign sw_clean = r_clean;
    assign sw_rise  = r_rise;

endmodule

`default_nettype wire

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed self-checking bench, WIDTH=16, DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_switch_conditioner;

    logic        clk;
    logic        rst;
    logic [15:0] sw_raw;
    logic [15:0] sw_clean;
    logic [15:0] sw_rise;
    logic [15:0] sw_fall;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] fall_bit1;

    switch_conditioner #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; returns 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef SWITCH_CONDITIONER_FALL_PULSE_EN
        fall_bit1 = 16'h0002;
`else
        fall_bit1 = 16'h0000;
`endif
        rst    = 1'b1;
        sw_raw = 16'h0000;
        tick(3);
        check("reset_clean", sw_clean, 16'h0000);
        check("reset_rise",  sw_rise,  16'h0000);
        check("reset_fall",  sw_fall,  16'h0000);
        rst = 1'b0;
        tick(3);

        // Clean press on bit 2: accepted on edge 6.
        sw_raw = 16'h0004;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check($sformatf("press_clean_e%0d", k), sw_clean, 16'h0000);
            check($sformatf("press_rise_e%0d", k),  sw_rise,  16'h0000);
        end
        tick(1);
        check("press_clean_e6", sw_clean, 16'h0004);
        check("press_rise_e6",  sw_rise,  16'h0004);
        tick(1);
        check("press_clean_e7", sw_clean, 16'h0004);
        check("press_rise_e7",  sw_rise,  16'h0000);

        // Glitch on bit 0: three samples high, never reaches terminal count.
        sw_raw = 16'h0005;
        tick(3);
        sw_raw = 16'h0004;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check($sformatf("glitch_clean_%0d", k), sw_clean, 16'h0004);
            check($sformatf("glitch_rise_%0d", k),  sw_rise,  16'h0000);
        end

        // Release on bit 1 after a stable high.
        sw_raw = 16'h0006;
        tick(10);
        check("rel_setup_clean", sw_clean, 16'h0006);
        sw_raw = 16'h0004;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check($sformatf("rel_clean_e%0d", k), sw_clean, 16'h0006);
            check($sformatf("rel_fall_e%0d", k),  sw_fall,  16'h0000);
        end
        tick(1);
        check("rel_clean_e6", sw_clean, 16'h0004);
        check("rel_fall_e6",  sw_fall,  fall_bit1);
        check("rel_rise_e6",  sw_rise,  16'h0000);
        tick(1);
        check("rel_fall_e7",  sw_fall,  16'h0000);

        // Multi-bit change lands on one edge.
        sw_raw = 16'h0000;
        tick(10);
        check("multi_setup_clean", sw_clean, 16'h0000);
        sw_raw = 16'hFFC0;
        tick(5);
        check("multi_clean_e5", sw_clean, 16'h0000);
        check("multi_rise_e5",  sw_rise,  16'h0000);
        tick(1);
        check("multi_clean_e6", sw_clean, 16'hFFC0);
        check("multi_rise_e6",  sw_rise,  16'hFFC0);
        tick(1);
        check("multi_rise_e7",  sw_rise,  16'h0000);

        // Reset asserted asynchronously with bit 3 at count 2.
        sw_raw = 16'hFFC8;
        tick(4);
        check("rstmid_clean_pre", sw_clean, 16'hFFC0);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_clean_async", sw_clean, 16'h0000);
        check("rstmid_rise_async",  sw_rise,  16'h0000);
        check("rstmid_fall_async",  sw_fall,  16'h0000);
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check($sformatf("rstrel_clean_e%0d", k), sw_clean, 16'h0000);
            check($sformatf("rstrel_rise_e%0d", k),  sw_rise,  16'h0000);
        end
        tick(1);
        check("rstrel_clean_e6", sw_clean, 16'hFFC8);
        check("rstrel_rise_e6",  sw_rise,  16'hFFC8);
        tick(1);
        check("rstrel_rise_e7",  sw_rise,  16'h0000);

        // Bounce train on bit 5, then a steady high.
        for (int seg = 0; seg < 10; seg++) begin
            sw_raw = (seg % 2 == 0) ? 16'hFFE8 : 16'hFFC8;
            for (int k = 0; k < 2; k++) begin
                tick(1);
                check($sformatf("bounce_rise_s%0d", seg),  sw_rise,  16'h0000);
                check($sformatf("bounce_clean_s%0d", seg), sw_clean, 16'hFFC8);
            end
        end
        sw_raw = 16'hFFE8;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check($sformatf("settle_rise_e%0d", k), sw_rise, 16'h0000);
        end
        tick(1);
        check("settle_rise_e6",  sw_rise,  16'h0020);
        check("settle_clean_e6", sw_clean, 16'hFFE8);
        tick(1);
        check("settle_rise_e7",  sw_rise,  16'h0000);
        tick(4);
        check("settle_rise_tail", sw_rise, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
